// File: rtl/icache_miss_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_miss_ctrl_if
//  Purpose  : Bundles the Icache miss handshake, the I-side memory request
//             port, the shared memory return bus and the Icache line-write
//             port used by icache_miss_ctrl.
//  Modports : master - the miss controller (drives requests and writes)
//             slave  - the surrounding Icache / memory environment
//  Signals  : miss_valid/miss_addr/miss_done  demand miss handshake
//             mshr_full                       all MSHR entries busy
//             Icache2Imem_command/addr        load request (BUS_NONE/BUS_LOAD)
//             Imem2Icache_response            0 = refused, else assigned tag
//             Imem2Icache_tag/data            broadcast return bus
//             wr_en/wr_addr/wr_data           Icache data-array line write
//  Revision : 1.0 - initial release
// ============================================================================
interface icache_miss_ctrl_if;
   logic        miss_valid;
   logic [31:0] miss_addr;
   logic        miss_done;
   logic        mshr_full;
   logic [1:0]  Icache2Imem_command;
   logic [31:0] Icache2Imem_addr;
   logic [3:0]  Imem2Icache_response;
   logic [63:0] Imem2Icache_data;
   logic [3:0]  Imem2Icache_tag;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [63:0] wr_data;

   modport master (
      input  miss_valid, miss_addr, Imem2Icache_response, Imem2Icache_data, Imem2Icache_tag,
      output miss_done, mshr_full, Icache2Imem_command, Icache2Imem_addr, wr_en, wr_addr, wr_data
   );

   modport slave (
      output miss_valid, miss_addr, Imem2Icache_response, Imem2Icache_data, Imem2Icache_tag,
      input  miss_done, mshr_full, Icache2Imem_command, Icache2Imem_addr, wr_en, wr_addr, wr_data
   );
endinterface
`default_nettype wire

// File: rtl/icache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icache_miss_ctrl
//  Purpose  : Icache miss handler. Requests the demand line plus
//             PREFETCH_DEPTH sequential lines, tracks outstanding tags in an
//             N_MSHR-entry table, and writes returning lines into the Icache.
//  Ports    : clock - system clock
//             reset - asynchronous active-high reset
//             bus   - icache_miss_ctrl_if.master (miss handshake, memory
//                     request/return, Icache line write)
//  Revision : 1.0 - initial release
// ============================================================================
module icache_miss_ctrl #(
   parameter int N_MSHR         = 4,
   parameter int PREFETCH_DEPTH = 2
) (
   input logic                 clock,
   input logic                 reset,
   icache_miss_ctrl_if.master  bus
);
   localparam int CNT_W = $clog2(PREFETCH_DEPTH + 2);
   localparam int IDX_W = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;

   localparam logic [1:0]       C_BUS_NONE = 2'd0;
   localparam logic [1:0]       C_BUS_LOAD = 2'd1;
   localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(PREFETCH_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t            r_state;
   logic [31:0]       r_base;
   logic [CNT_W-1:0]  r_issue_cnt;
   logic              r_demand_done;
   logic [N_MSHR-1:0] r_valid;
   logic [3:0]        r_tag  [N_MSHR];
   logic [31:0]       r_addr [N_MSHR];
   logic              r_miss_done;
   logic              r_mshr_full;
   logic              r_wr_en;
   logic [31:0]       r_wr_addr;
   logic [63:0]       r_wr_data;

   logic [31:0]       w_cand;
   logic              w_cnt_done;
   logic              w_dup;
   logic              w_free_any;
   logic [IDX_W-1:0]  w_free_idx;
   logic [N_MSHR-1:0] w_match;
   logic              w_hit;
   logic [31:0]       w_hit_addr;
   logic              w_issuing;
   logic              w_alloc;
   logic [N_MSHR-1:0] w_valid_next;

   // Duplicate and free-entry decisions use start-of-cycle valid bits, so an
   // entry retiring this cycle still blocks its address and cannot be reused.
   always_comb begin
      w_cand     = r_base + (32'(r_issue_cnt) << 3);
      w_cnt_done = (r_issue_cnt > C_LAST_CNT);
      w_dup      = 1'b0;
      w_free_any = 1'b0;
      w_free_idx = '0;
      w_match    = '0;
      w_hit_addr = '0;
      // Descending scan so the lowest free index wins.
      for (int i = N_MSHR - 1; i >= 0; i--) begin
         if (r_valid[i] && (r_addr[i] == w_cand)) begin
            w_dup = 1'b1;
         end
         if (!r_valid[i]) begin
            w_free_any = 1'b1;
            w_free_idx = IDX_W'(i);
         end
         if (r_valid[i] && (bus.Imem2Icache_tag != 4'd0) && (r_tag[i] == bus.Imem2Icache_tag)) begin
            w_match[i] = 1'b1;
            w_hit_addr = w_hit_addr | r_addr[i];
         end
      end
      w_hit        = |w_match;
      w_issuing    = (r_state == S_ISSUE) && !w_cnt_done && !w_dup && w_free_any;
      w_alloc      = w_issuing && (bus.Imem2Icache_response != 4'd0);
      w_valid_next = r_valid & ~w_match;
      if (w_alloc) begin
         w_valid_next[w_free_idx] = 1'b1;
      end
   end

   // Request is combinational so a refused request is simply re-driven.
   assign bus.Icache2Imem_command = w_issuing ? C_BUS_LOAD : C_BUS_NONE;
   assign bus.Icache2Imem_addr    = w_issuing ? w_cand : 32'd0;
   assign bus.miss_done           = r_miss_done;
   assign bus.mshr_full           = r_mshr_full;
   assign bus.wr_en               = r_wr_en;
   assign bus.wr_addr             = r_wr_addr;
   assign bus.wr_data             = r_wr_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_base        <= '0;
         r_issue_cnt   <= '0;
         r_demand_done <= 1'b0;
         r_valid       <= '0;
         r_miss_done   <= 1'b0;
         r_mshr_full   <= 1'b0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         for (int i = 0; i < N_MSHR; i++) begin
            r_tag[i]  <= '0;
            r_addr[i] <= '0;
         end
      end else begin
         r_valid     <= w_valid_next;
         r_mshr_full <= &w_valid_next;
         if (w_alloc) begin
            r_tag[w_free_idx]  <= bus.Imem2Icache_response;
            r_addr[w_free_idx] <= w_cand;
         end

         r_wr_en     <= w_hit;
         r_miss_done <= 1'b0;
         if (w_hit) begin
            r_wr_addr <= w_hit_addr;
            r_wr_data <= bus.Imem2Icache_data;
         end
         // Also catches a demand line that was already in flight as a prefetch.
         if (w_hit && (w_hit_addr == r_base) && (r_state != S_IDLE) && !r_demand_done) begin
            r_miss_done   <= 1'b1;
            r_demand_done <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (bus.miss_valid) begin
                  r_base        <= bus.miss_addr & ~32'h7;
                  r_issue_cnt   <= '0;
                  r_demand_done <= 1'b0;
                  r_state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_cnt_done) begin
                  r_state <= r_demand_done ? S_IDLE : S_WAIT;
               end else if (w_dup || w_alloc) begin
                  r_issue_cnt <= r_issue_cnt + CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (r_demand_done) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   // A returning tag may own at most one entry.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert ($onehot0(w_match));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_miss_ctrl
//  Purpose  : Directed self-checking bench for icache_miss_ctrl: basic miss,
//             bus contention, prefetched demand, MSHR full stall, foreign tag,
//             address wrap and reset mid-operation.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_miss_ctrl;
   localparam logic [1:0] NONE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   icache_miss_ctrl_if bus ();

   icache_miss_ctrl #(
      .N_MSHR         (4),
      .PREFETCH_DEPTH (2)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic chk_req(input string name, input logic [1:0] cmd, input logic [31:0] addr);
      chk({name, "_cmd"}, 64'(bus.Icache2Imem_command), 64'(cmd));
      chk({name, "_addr"}, 64'(bus.Icache2Imem_addr), 64'(addr));
   endtask

   task automatic chk_wr(input string name, input logic en, input logic [31:0] addr,
                         input logic [63:0] data, input logic done);
      chk({name, "_wr_en"}, 64'(bus.wr_en), 64'(en));
      if (en) begin
         chk({name, "_wr_addr"}, 64'(bus.wr_addr), 64'(addr));
         chk({name, "_wr_data"}, bus.wr_data, data);
      end
      chk({name, "_miss_done"}, 64'(bus.miss_done), 64'(done));
   endtask

   // Drive the return bus and response for the current cycle.
   task automatic drive(input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] data);
      bus.Imem2Icache_response = resp;
      bus.Imem2Icache_tag      = tag;
      bus.Imem2Icache_data     = data;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.miss_valid = 1'b0;
      bus.miss_addr  = 32'd0;
      bus.Imem2Icache_response = 4'd0;
      bus.Imem2Icache_tag      = 4'd0;
      bus.Imem2Icache_data     = 64'd0;

      // Reset state
      tick(); tick();
      chk_req("rst", NONE, 32'h0);
      chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
      chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
      chk("rst_wr_data", bus.wr_data, 64'd0);
      chk("rst_miss_done", 64'(bus.miss_done), 64'd0);
      chk("rst_full", 64'(bus.mshr_full), 64'd0);
      rst = 1'b0;

      // Basic miss at 0x1004 -> lines 0x1000/0x1008/0x1010 as tags 3/5/7
      tick(); bus.miss_valid = 1'b1; bus.miss_addr = 32'h1004; drive(0, 0, 0);
      chk_req("t1_idle", NONE, 32'h0);
      tick(); drive(3, 0, 0); chk_req("t1_req0", LOAD, 32'h1000);
      tick(); drive(5, 0, 0); chk_req("t1_req1", LOAD, 32'h1008);
      tick(); drive(7, 0, 0); chk_req("t1_req2", LOAD, 32'h1010);
      tick(); drive(0, 0, 0); chk_req("t1_done", NONE, 32'h0);
      chk("t1_full", 64'(bus.mshr_full), 64'd0);
      tick(); drive(0, 5, 64'hAA);
      tick(); drive(0, 3, 64'hBB);
      chk_wr("t1_pf", 1'b1, 32'h1008, 64'hAA, 1'b0);
      tick(); drive(0, 0, 0);
      chk_wr("t1_dem", 1'b1, 32'h1000, 64'hBB, 1'b1);
      bus.miss_valid = 1'b0;

      // Bus contention on 0x2000; FSM must already be back in IDLE
      tick(); bus.miss_valid = 1'b1; bus.miss_addr = 32'h2000; drive(0, 0, 0);
      chk_wr("t2_idle", 1'b0, 32'h0, 64'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); drive(0, 0, 0); chk_req("t2_hold", LOAD, 32'h2000);
      end
      tick(); drive(4, 0, 0); chk_req("t2_acc", LOAD, 32'h2000);
      tick(); drive(6, 0, 0); chk_req("t2_adv", LOAD, 32'h2008);
      tick(); drive(8, 0, 0); chk_req("t2_req2", LOAD, 32'h2010);
      tick(); drive(0, 4, 64'h44); chk_req("t2_done", NONE, 32'h0);
      chk("t2_full", 64'(bus.mshr_full), 64'd1);
      tick(); drive(0, 0, 0);
      chk_wr("t2_dem", 1'b1, 32'h2000, 64'h44, 1'b1);
      chk("t2_full_clr", 64'(bus.mshr_full), 64'd0);
      bus.miss_valid = 1'b0;

      // Prefetches drain while IDLE; no miss_done for them
      tick(); drive(0, 7, 64'h77);
      tick(); drive(0, 8, 64'h88);
      chk_wr("t3_pf7", 1'b1, 32'h1010, 64'h77, 1'b0);
      // 0x2008 still outstanding as tag 6; new miss at 0x200C
      tick(); bus.miss_valid = 1'b1; bus.miss_addr = 32'h200C; drive(0, 0, 0);
      chk_wr("t3_pf8", 1'b1, 32'h2010, 64'h88, 1'b0);
      tick(); drive(0, 0, 0); chk_req("t3_dup", NONE, 32'h0);
      tick(); drive(9, 0, 0); chk_req("t3_req1", LOAD, 32'h2010);
      tick(); drive(10, 0, 0); chk_req("t3_req2", LOAD, 32'h2018);
      tick(); drive(0, 6, 64'h66); chk_req("t3_done", NONE, 32'h0);
      tick(); drive(0, 0, 0);
      chk_wr("t3_dem", 1'b1, 32'h2008, 64'h66, 1'b1);
      bus.miss_valid = 1'b0;

      // MSHR full stall: entries hold tags 9 (0x2010) and 10 (0x2018)
      tick(); bus.miss_valid = 1'b1; bus.miss_addr = 32'h3000; drive(0, 0, 0);
      tick(); drive(1, 0, 0); chk_req("t4_req0", LOAD, 32'h3000);
      tick(); drive(2, 0, 0); chk_req("t4_req1", LOAD, 32'h3008);
      tick(); drive(3, 9, 64'h99); chk_req("t4_stall", NONE, 32'h0);
      chk("t4_full", 64'(bus.mshr_full), 64'd1);
      tick(); drive(5, 0, 0); chk_req("t4_reissue", LOAD, 32'h3010);
      chk_wr("t4_ret9", 1'b1, 32'h2010, 64'h99, 1'b0);
      chk("t4_full_clr", 64'(bus.mshr_full), 64'd0);
      tick(); drive(0, 1, 64'h31); chk_req("t4_done", NONE, 32'h0);
      chk("t4_full2", 64'(bus.mshr_full), 64'd1);
      tick(); drive(0, 0, 0);
      chk_wr("t4_dem", 1'b1, 32'h3000, 64'h31, 1'b1);
      bus.miss_valid = 1'b0;

      // Foreign tag, then drain remaining entries (10, 2, 5)
      tick(); drive(0, 9, 64'hDEAD);
      tick(); drive(0, 10, 64'hA0);
      chk_wr("t5_foreign", 1'b0, 32'h0, 64'h0, 1'b0);
      tick(); drive(0, 2, 64'h20);
      chk_wr("t5_retA", 1'b1, 32'h2018, 64'hA0, 1'b0);
      tick(); drive(0, 5, 64'h55);
      chk_wr("t5_ret2", 1'b1, 32'h3008, 64'h20, 1'b0);
      tick(); bus.miss_valid = 1'b1; bus.miss_addr = 32'hFFFF_FFFC; drive(0, 0, 0);
      chk_wr("t5_ret5", 1'b1, 32'h3010, 64'h55, 1'b0);
      // Address wrap
      tick(); drive(1, 0, 0); chk_req("t5_wrap0", LOAD, 32'hFFFF_FFF8);
      tick(); drive(2, 0, 0); chk_req("t5_wrap1", LOAD, 32'h0000_0000);
      tick(); drive(0, 0, 0); chk_req("t5_wrap2", LOAD, 32'h0000_0008);

      // Reset mid-ISSUE with tags 1 and 2 outstanding
      rst = 1'b1;
      bus.miss_valid = 1'b0;
      #1;
      chk_req("t6_rst", NONE, 32'h0);
      chk("t6_wr_en", 64'(bus.wr_en), 64'd0);
      chk("t6_wr_addr", 64'(bus.wr_addr), 64'd0);
      chk("t6_wr_data", bus.wr_data, 64'd0);
      chk("t6_full", 64'(bus.mshr_full), 64'd0);
      tick();
      rst = 1'b0;
      tick(); drive(0, 1, 64'h11);
      tick(); drive(0, 2, 64'h22);
      chk_wr("t6_ret1", 1'b0, 32'h0, 64'h0, 1'b0);
      tick(); drive(0, 0, 0);
      chk_wr("t6_ret2", 1'b0, 32'h0, 64'h0, 1'b0);
      chk("t6_wr_addr2", 64'(bus.wr_addr), 64'd0);
      chk_req("t6_idle", NONE, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/icache_miss_ctrl.md
Name: icache_miss_ctrl

Overview:
- Instruction-cache miss handler sitting directly upstream of the I-side memory port.
- Takes a demand line miss from the Icache and issues `BUS_LOAD` for the demand line plus PREFETCH_DEPTH sequential next lines.
- Tracks outstanding memory tags in a small MSHR table.
- Writes returning 64-bit lines into the Icache data array.
- Also consumes the broadcast memory tag/data bus that is shared with the Dcache side.

Parameters:
- N_MSHR, 4, number of outstanding-load entries (tag + line address).
- PREFETCH_DEPTH, 2, sequential lines requested after the demand line (0 = demand only).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- miss_valid  input  1  Icache demand miss; held high until miss_done
- miss_addr  input  32  PC_t miss address; bits [2:0] ignored (8-byte lines)
- miss_done  output  1  one-cycle pulse when the demand line is written
- mshr_full  output  1  all N_MSHR entries valid
- Icache2Imem_command  output  2  BUS_NONE / BUS_LOAD
- Icache2Imem_addr  output  32  PC_t line-aligned request address
- Imem2Icache_response  input  4  0 = not accepted, else tag assigned
- Imem2Icache_data  input  64  returning line data
- Imem2Icache_tag  input  4  0 = no return, else tag of completed load
- wr_en  output  1  Icache line write strobe
- wr_addr  output  32  PC_t line address being written
- wr_data  output  64  line data being written

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; all MSHR entries invalid; issue_cnt = 0; demand_done = 0.
  - Outputs: command BUS_NONE, addr 0, wr_en 0, wr_addr 0, wr_data 0, miss_done 0, mshr_full 0.
  - Tags returning after reset match nothing and are ignored.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - When miss_valid = 1, latch base = {miss_addr[31:3], 3'b0}, set issue_cnt = 0, clear demand_done, and go to ISSUE next cycle.
  - miss_valid outside IDLE is ignored.
- ISSUE, cycle-level rules:
  - Candidate address is cand = base + 8*issue_cnt, mod 2^32 (wraps silently).
  - If cand equals the address of a valid MSHR entry: no request; issue_cnt++.
  - Else, if an entry is free (judged on start-of-cycle valid bits): drive BUS_LOAD / cand combinationally.
    - If Imem2Icache_response != 0: allocate the lowest free entry {valid, tag = response, addr = cand}; issue_cnt++.
    - If response == 0 (Dcache owns the bus, or memory is busy): hold the same cand next cycle.
  - Else (MSHR full): drive BUS_NONE and stall.
  - When issue_cnt > PREFETCH_DEPTH: go to IDLE if demand_done, else to WAIT.
- WAIT: drive BUS_NONE; go to IDLE in the cycle after miss_done pulses.
- Return path (all states):
  - If Imem2Icache_tag != 0 and it matches a valid entry: next cycle wr_en = 1, wr_addr = entry addr, wr_data = data sampled with the tag. The entry is invalidated at that same edge.
  - A tag matching no entry belongs to the Dcache and is ignored.
  - A match on more than one entry cannot occur; it is an assertion failure.
- Demand completion:
  - miss_done = 1 in the same cycle as wr_en when wr_addr == base, FSM != IDLE and demand_done == 0; demand_done is then set.
  - This covers a demand line already in flight from an earlier prefetch.
- Simultaneous events:
  - Retire happens before allocate.
  - An entry freed this cycle is not reusable until next cycle.
  - A response tag equal to the tag retiring this cycle is legal, and allocates a different (free) entry.
- mshr_full is registered: 1 when all entries are valid after the edge.
- Outstanding prefetches survive the return to IDLE; a new miss may start while they are pending.

Test Plan:
- Basic miss: miss_addr 0x1004, response 3, 5, 7 on consecutive cycles -> BUS_LOAD 0x1000, 0x1008, 0x1010. Then tag 5 with data 0xAA -> wr_en, wr_addr 0x1008, no miss_done. Then tag 3 -> wr_addr 0x1000 with miss_done, FSM returns to IDLE.
- Bus contention: response 0 for 3 cycles on 0x2000 -> address held at 0x2000 all 3 cycles, no allocation. Response 4 on the 4th cycle -> advances to 0x2008.
- Duplicate / prefetched demand: 0x1008 outstanding as tag 5; new miss at 0x1008 -> no BUS_LOAD for 0x1008, requests 0x1010 and 0x1018. Tag 5 return -> miss_done.
- MSHR full: N_MSHR = 4 all valid -> BUS_NONE and mshr_full = 1. One tag returns -> request reissued the following cycle.
- Foreign tag and wrap: tag 9 with no matching entry -> no wr_en. Miss at 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0x0000_0000, 0x0000_0008.
- Reset mid-operation: reset in ISSUE with 2 entries valid -> outputs zero immediately. Later returns of those tags -> no wr_en and no miss_done.
